// File: rtl/tmds_rx_align.sv
// TMDS receive word aligner: searches bit offsets for runs of control tokens and barrel-shifts
// the raw 1:10 stream into aligned words. Decoder is built only when TMDS_DECODE_EN is defined.
module tmds_rx_align #(
  parameter int SEARCH_CYCLES = 4096,
  parameter int TOKEN_RUN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] i_dat_10bit,
  output logic [9:0] o_dat_10bit,
  output logic [7:0] o_d,
  output logic [1:0] o_c,
  output logic       o_de,
  output logic       o_locked,
  output logic [3:0] o_offset
);
  localparam logic [15:0] TIMER_END = 16'(SEARCH_CYCLES - 1);
  localparam logic [7:0]  RUN_LOCK  = 8'(TOKEN_RUN);

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  state_t      state_q, state_d;
  logic [3:0]  offset_q, offset_d, offset_adv;
  logic [7:0]  run_q, run_d, run_inc;
  logic [15:0] timer_q, timer_d, timer_inc;
  logic        skip_q, skip_d;
  logic [9:0]  prev_q, prev_d, aln_q, aln_d, dat_q;
  logic [19:0] window;
  logic        tok;

  assign prev_d     = i_dat_10bit;
  assign window     = {i_dat_10bit, prev_q};
  assign aln_d      = window[{1'b0, offset_q} +: 10];
  assign offset_adv = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
  assign run_inc    = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
  assign timer_inc  = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

  always_comb begin
    tok = 1'b0;
    case (aln_q)
      10'b1101010100, 10'b0010101011,
      10'b0101010100, 10'b1010101011: tok = 1'b1;
      default:                        tok = 1'b0;
    endcase
  end

  // skip_q masks the one aln_q word that was still cut at the previous offset
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_q;
    timer_d  = timer_q;
    skip_d   = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        run_d   = (tok && !skip_q) ? run_inc : 8'd0;
        timer_d = timer_inc;
        if (run_d >= RUN_LOCK) begin
          state_d = ST_LOCKED;
          timer_d = 16'd0;
        end else if (timer_q >= TIMER_END) begin
          offset_d = offset_adv;
          timer_d  = 16'd0;
          run_d    = 8'd0;
          skip_d   = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (tok) begin
          timer_d = 16'd0;
        end else if (timer_q >= TIMER_END) begin
          state_d  = ST_SEARCH;
          offset_d = offset_adv;
          timer_d  = 16'd0;
          run_d    = 8'd0;
          skip_d   = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SEARCH;
      offset_q <= 4'd0;
      run_q    <= 8'd0;
      timer_q  <= 16'd0;
      skip_q   <= 1'b0;
      prev_q   <= 10'd0;
      aln_q    <= 10'd0;
      dat_q    <= 10'd0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      run_q    <= run_d;
      timer_q  <= timer_d;
      skip_q   <= skip_d;
      prev_q   <= prev_d;
      aln_q    <= aln_d;
      dat_q    <= aln_q;
    end
  end

  assign o_dat_10bit = dat_q;
  assign o_locked    = (state_q == ST_LOCKED);
  assign o_offset    = offset_q;

`ifdef TMDS_DECODE_EN
  logic [8:0] q_w;
  logic [7:0] d_d, d_q;
  logic [1:0] c_d, c_q;
  logic       de_d, de_q;

  always_comb begin
    q_w    = aln_q[9] ? {aln_q[8], ~aln_q[7:0]} : aln_q[8:0];
    d_d    = 8'd0;
    d_d[0] = q_w[0];
    for (int i = 1; i < 8; i++) begin
      d_d[i] = q_w[8] ? (q_w[i] ^ q_w[i-1]) : ~(q_w[i] ^ q_w[i-1]);
    end
    de_d = 1'b1;
    c_d  = 2'b00;
    case (aln_q)
      10'b1101010100: begin de_d = 1'b0; c_d = 2'b00; d_d = 8'd0; end
      10'b0010101011: begin de_d = 1'b0; c_d = 2'b01; d_d = 8'd0; end
      10'b0101010100: begin de_d = 1'b0; c_d = 2'b10; d_d = 8'd0; end
      10'b1010101011: begin de_d = 1'b0; c_d = 2'b11; d_d = 8'd0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q  <= 8'd0;
      c_q  <= 2'b00;
      de_q <= 1'b0;
    end else begin
      d_q  <= d_d;
      c_q  <= c_d;
      de_q <= de_d;
    end
  end

  assign o_d  = d_q;
  assign o_c  = c_q;
  assign o_de = de_q;
`else
  assign o_d  = 8'd0;
  assign o_c  = 2'b00;
  assign o_de = 1'b0;
`endif
endmodule

// File: tb/tb_tmds_rx_align.sv
// Randomized bench for tmds_rx_align: a serial bit-stream generator feeds the DUT and a
// behavioural model (bit queue + integer search/lock rules) predicts every output each cycle.
module tb_tmds_rx_align;
  localparam int SC = 64;
  localparam int TR = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] i_dat = 10'd0;
  logic [9:0] o_dat_10bit;
  logic [7:0] o_d;
  logic [1:0] o_c;
  logic       o_de, o_locked;
  logic [3:0] o_offset;

  tmds_rx_align #(.SEARCH_CYCLES(SC), .TOKEN_RUN(TR)) dut (
    .clk(clk), .rst_n(rst_n), .i_dat_10bit(i_dat), .o_dat_10bit(o_dat_10bit),
    .o_d(o_d), .o_c(o_c), .o_de(o_de), .o_locked(o_locked), .o_offset(o_offset)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model state
  bit         m_locked;
  int         m_off, m_run, m_timer;
  bit         m_skip;
  logic [9:0] m_aln, m_out;
  bit         mb[$];   // received serial bits, previous word then current word
  bit         sq[$];   // transmit-side serial bit queue
  int         rot;
  bit         seen_lock;

  localparam logic [9:0] TK0 = 10'b1101010100;
  localparam logic [9:0] TK1 = 10'b0010101011;
  localparam logic [9:0] TK2 = 10'b0101010100;
  localparam logic [9:0] TK3 = 10'b1010101011;

  function automatic bit is_tok(input logic [9:0] w);
    return (w == TK0) || (w == TK1) || (w == TK2) || (w == TK3);
  endfunction

  // returns {de, c[1:0], d[7:0]}
  function automatic logic [10:0] dec(input logic [9:0] w);
    logic [8:0] q;
    logic [7:0] d;
    if (w == TK0) return 11'b0_00_00000000;
    if (w == TK1) return 11'b0_01_00000000;
    if (w == TK2) return 11'b0_10_00000000;
    if (w == TK3) return 11'b0_11_00000000;
    q = w[8:0];
    if (w[9]) q[7:0] = ~w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ ~q[8];
    return {1'b1, 2'b00, d};
  endfunction

  function automatic logic [9:0] pick_tok(input int k);
    case (k)
      0: return TK0;
      1: return TK1;
      2: return TK2;
      default: return TK3;
    endcase
  endfunction

  task automatic model_reset();
    m_locked = 1'b0; m_off = 0; m_run = 0; m_timer = 0; m_skip = 1'b0;
    m_aln = 10'd0; m_out = 10'd0;
    mb.delete();
    repeat (10) mb.push_back(1'b0);
  endtask

  task automatic advance();
    m_off   = (m_off + 1) % 10;
    m_timer = 0;
    m_run   = 0;
    m_skip  = 1'b1;
  endtask

  task automatic model_edge(input logic [9:0] w);
    bit         t;
    logic [9:0] na;
    t = is_tok(m_aln);
    for (int j = 0; j < 10; j++) mb.push_back(w[j]);
    for (int j = 0; j < 10; j++) na[j] = mb[m_off + j];
    repeat (10) void'(mb.pop_front());
    m_out = m_aln;
    m_aln = na;
    if (!m_locked) begin
      m_run  = (t && !m_skip) ? ((m_run < 255) ? m_run + 1 : 255) : 0;
      m_skip = 1'b0;
      if (m_run >= TR) begin
        m_locked = 1'b1;
        m_timer  = 0;
      end else if (m_timer == SC - 1) begin
        advance();
      end else begin
        m_timer++;
      end
    end else begin
      m_skip = 1'b0;
      if (t) m_timer = 0;
      else if (m_timer == SC - 1) begin
        m_locked = 1'b0;
        advance();
      end else m_timer++;
    end
  endtask

  task automatic compare_all();
    logic [10:0] e;
    chk("locked", 32'(o_locked), 32'(m_locked));
    chk("offset", 32'(o_offset), 32'(m_off));
    chk("dat", 32'(o_dat_10bit), 32'(m_out));
`ifdef TMDS_DECODE_EN
    e = dec(m_out);
`else
    e = 11'd0;
`endif
    chk("de", 32'(o_de), 32'(e[10]));
    chk("c", 32'(o_c), 32'(e[9:8]));
    chk("d", 32'(o_d), 32'(e[7:0]));
  endtask

  task automatic step(input logic [9:0] w);
    i_dat = w;
    @(posedge clk);
    if (rst_n) model_edge(w);
    @(negedge clk);
    compare_all();
    seen_lock |= o_locked;
  endtask

  task automatic send(input logic [9:0] w);
    logic [9:0] x;
    for (int j = 0; j < 10; j++) sq.push_back(w[j]);
    while (sq.size() >= 10) begin
      for (int j = 0; j < 10; j++) x[j] = sq.pop_front();
      step(x);
    end
  endtask

  task automatic skew(input int n);
    for (int j = 0; j < n; j++) sq.push_back(1'($urandom_range(0, 1)));
    rot = (rot + n) % 10;
  endtask

  // called at a negedge; reset asserts mid-cycle and spans one rising edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    chk("rst_locked", 32'(o_locked), 32'd0);
    chk("rst_offset", 32'(o_offset), 32'd0);
    chk("rst_dat", 32'(o_dat_10bit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] tk;
    int n;
    model_reset();
    rot = 0;
    seen_lock = 1'b0;
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // aligned stream, 16 tokens then data
    tk = pick_tok($urandom_range(0, 3));
    repeat (5) begin
      repeat (16) send(tk);
      repeat (4) send(10'h133);
    end
    repeat (16) send(TK0);
    repeat (3) send(10'h133);
    chk("s1_locked", 32'(o_locked), 32'd1);
    chk("s1_offset", 32'(o_offset), 32'd0);
`ifdef TMDS_DECODE_EN
    chk("s1_d55", 32'(o_d), 32'h55);
    chk("s1_de", 32'(o_de), 32'd1);
`endif

    // rotation 3 with blanking tokens, then lock loss
    do_reset(); sq.delete(); rot = 0;
    skew(3);
    repeat (4 * SC + 40) send(TK2);
    chk("s2_locked", 32'(o_locked), 32'd1);
    chk("s2_offset", 32'(o_offset), 32'(rot));
`ifdef TMDS_DECODE_EN
    chk("s2_c", 32'(o_c), 32'b10);
`endif
    repeat (SC + 6) send(10'h133);
    chk("s3_locked", 32'(o_locked), 32'd0);
    chk("s3_offset", 32'(o_offset), 32'd4);

    // lock at 9, lose lock, wrap to 0, then re-lock on a new random rotation
    do_reset(); sq.delete(); rot = 0;
    skew(9);
    repeat (9 * SC + 40) send(TK2);
    chk("s4_lock9", 32'(o_offset), 32'd9);
    repeat (SC + 6) send(10'h133);
    chk("s4_wrap", 32'(o_offset), 32'd0);
    chk("s4_unlocked", 32'(o_locked), 32'd0);
    n = $urandom_range(0, 9);
    skew(n);
    repeat (10 * SC + 40) send(TK0);
    chk("s4_relock", 32'(o_locked), 32'd1);
    chk("s4_reoffset", 32'(o_offset), 32'(rot));

    // runs of 7 tokens never lock
    do_reset(); sq.delete(); rot = 0;
    seen_lock = 1'b0;
    repeat (30) begin
      repeat (7) send(TK0);
      send(10'h133);
    end
    chk("s5_nolock", 32'(seen_lock), 32'd0);
    chk("s5_offset", 32'(o_offset), 32'd3);

    // reset while locked at offset 5, then normal re-lock
    do_reset(); sq.delete(); rot = 0;
    skew(5);
    repeat (5 * SC + 40) send(TK2);
    chk("s6_locked", 32'(o_locked), 32'd1);
    chk("s6_offset", 32'(o_offset), 32'd5);
    do_reset();
    repeat (5 * SC + 40) send(TK2);
    chk("s6_relock", 32'(o_locked), 32'd1);
    chk("s6_reoffset", 32'(o_offset), 32'd5);

    // random soak: token bursts and random words on a random rotation
    do_reset(); sq.delete(); rot = 0;
    skew($urandom_range(0, 9));
    repeat (120) begin
      if ($urandom_range(0, 1) == 0) begin
        tk = pick_tok($urandom_range(0, 3));
        repeat ($urandom_range(1, 12)) send(tk);
      end else begin
        repeat ($urandom_range(1, 20)) send(10'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tmds_rx_align.md
# tmds_rx_align

- Receive-side counterpart of the TMDS 10:1 serializer. Sits behind a 1:10 deserializer, which delivers raw 10-bit words with arbitrary bit rotation.
- Finds the word boundary by searching for runs of TMDS control tokens and barrel-shifts the raw stream into aligned words.
- Optionally decodes each aligned word to 8-bit pixel data or a 2-bit control value.
- One instance per TMDS channel, in the pixel clock domain.

## Interface
- SEARCH_CYCLES, 4096: cycles without a qualifying token before trying the next offset. Range 16..65535.
- TOKEN_RUN, 8: consecutive control tokens needed to declare lock. Range 2..255.
- clk  in  1  pixel clock (deserializer CLKDIV domain)
- rst_n  in  1  reset; asynchronous and active-low
- i_dat_10bit  in  10  raw deserialized word; bit 0 is the earliest received bit
- o_dat_10bit  out  10  aligned TMDS word
- o_d  out  8  decoded data
- o_c  out  2  decoded control value; valid when o_de=0
- o_de  out  1  0 when the aligned word is a control token, else 1
- o_locked  out  1  alignment locked
- o_offset  out  4  current bit offset, 0..9

## Operation
- prev_q holds i_dat_10bit from the previous clk. The 20-bit window is {i_dat_10bit, prev_q}.
- The aligned word is window[offset+9:offset], registered into aln_q.
- Control tokens (bit 9..0), all four treated equally:
  - 10'b1101010100 → c=00
  - 10'b0010101011 → c=01
  - 10'b0101010100 → c=10
  - 10'b1010101011 → c=11
- tok = aln_q matches any token (combinational).
- FSM state SEARCH:
  - run increments on tok and clears on !tok.
  - timer increments every cycle.
  - When run reaches TOKEN_RUN: go to LOCKED and clear the timer.
  - Else, when timer reaches SEARCH_CYCLES-1: offset ← (offset==9) ? 0 : offset+1, then clear timer and run.
  - If both happen in the same cycle, lock wins.
- FSM state LOCKED:
  - Watchdog timer clears on every tok.
  - When the timer reaches SEARCH_CYCLES-1: go to SEARCH, advance offset (same wrap), clear timer and run.
- The first aln_q after any offset change is not counted as a token; run stays 0 for that cycle.
- Data keeps flowing to the outputs in both states. o_locked qualifies it.
- Decode (TMDS_DECODE_EN):
  - q = aln_q[9] ? {aln_q[9:8], ~aln_q[7:0]} : aln_q.
  - d[0] = q[0].
  - d[i] = q[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]), for i=1..7.
  - On tok: o_de=0, o_c=token value, o_d=0.
  - Otherwise: o_de=1, o_c=0, o_d=d.
- Reset values: all outputs 0, FSM=SEARCH, offset=0, run=0, timer=0, prev_q=0, aln_q=0. Assertion mid-operation returns to this state immediately.
- Counters: timer is 16-bit and run is 8-bit. Both saturate and never wrap.

## Timing
- Data latency at offset 0: input sampled at edge N appears on o_dat_10bit/o_d/o_c/o_de after edge N+2. Offset k>0 adds bits from input N+1, with the same output edge.
- o_locked rises on the edge after the TOKEN_RUN-th consecutive token appears in aln_q.
- o_offset and o_locked update on the same edge as the FSM transition that changes them.
- Offset advance period while unlocked: exactly SEARCH_CYCLES clk.
- Lock loss: SEARCH_CYCLES clk after the last token.
- No handshake: the output is valid every cycle.

## Configuration
- TMDS_DECODE_EN defined: the decoder is built and o_d/o_c/o_de are driven as in Operation. Decode is registered in the same stage as o_dat_10bit, so there is no added latency.
- TMDS_DECODE_EN undefined: o_d, o_c and o_de are constant 0.
- Alignment, o_dat_10bit, o_locked and o_offset are unchanged in both builds, and the port list is identical.

## Test plan
- Bench parameters: SEARCH_CYCLES=64, TOKEN_RUN=8.
- Aligned stream of 16×10'b1101010100 then 10'h133 repeating → o_locked=1, o_offset=0 after 8 tokens. Then o_de=0, o_c=00 during tokens; o_de=1, o_d=8'h55 on 10'h133 (decode build).
- Same stream rotated by 3 bits, continuous blanking tokens (10'b0101010100) → offset steps 0,1,2,3 at 64-clk intervals; o_locked=1 with o_offset=3 after 8 tokens at offset 3; o_c=10.
- Locked, then only 10'h133 for 64 clk → o_locked falls after the 64th clk; o_offset advances by 1.
- Rotation of 9 bits after lock loss at offset 9 → offset wraps to 0, then re-locks on the correct offset.
- Token run of 7 then one 10'h133, repeating → o_locked stays 0 and offset keeps advancing.
- rst_n low for 1 clk while locked at offset 5 → o_locked=0, o_offset=0, all data outputs 0 immediately (asynchronous). Re-lock follows the normal search.
